// File: rtl/ifetch_queue.sv
// Instruction fetch stage: owns the fetch pointer, reads a combinational imem
// once per cycle and buffers {pc, op} pairs in a small FIFO feeding the decoder.
module ifetch_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 9,
    parameter int OP_W  = 32,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [OP_W-1:0]  imem_op,
    input  logic             redirect,
    input  logic [PC_W-1:0]  redirect_pc,
    output logic             op_valid,
    output logic [OP_W-1:0]  op_out,
    output logic [PC_W-1:0]  op_pc,
    input  logic             op_ready,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [OP_W-1:0] op;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PC_W-1:0]   fpc_q, fpc_d;
    logic              pop, push;

    assign pop  = (count_q != '0) & op_ready;
    // A full FIFO may still accept a word when the head leaves in the same cycle.
    assign push = ~redirect & ((count_q < DEPTH_C) | pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        fpc_d    = fpc_q;
        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            fpc_d    = redirect_pc;
        end else begin
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                fpc_d    = fpc_q + PC_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            fpc_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            fpc_q    <= fpc_d;
            if (push) mem_q[wr_ptr_q] <= '{pc: fpc_q, op: imem_op};
        end
    end

    assign imem_addr = fpc_q;
    assign op_valid  = (count_q != '0);
    assign op_out    = mem_q[rd_ptr_q].op;
    assign op_pc     = mem_q[rd_ptr_q].pc;
    assign count     = count_q;
endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based model.
module tb_ifetch_queue;
    localparam int DEPTH = 4;
    localparam int PC_W  = 9;
    localparam int OP_W  = 32;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [PC_W-1:0]  imem_addr;
    logic [OP_W-1:0]  imem_op;
    logic             redirect;
    logic [PC_W-1:0]  redirect_pc;
    logic             op_valid;
    logic [OP_W-1:0]  op_out;
    logic [PC_W-1:0]  op_pc;
    logic             op_ready;
    logic [CNT_W-1:0] count;
    logic [OP_W-1:0]  key;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Memory contents are the address xor a key, so op and pc are distinguishable
    // once the key is non-zero.
    assign imem_op = {{(OP_W-PC_W){1'b0}}, imem_addr} ^ key;

    ifetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_op(imem_op),
        .redirect(redirect), .redirect_pc(redirect_pc), .op_valid(op_valid),
        .op_out(op_out), .op_pc(op_pc), .op_ready(op_ready), .count(count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: fetch pointer plus a queue of buffered words.
    logic [PC_W-1:0] m_fpc;
    logic [PC_W-1:0] m_pcq[$];
    logic [OP_W-1:0] m_opq[$];
    bit              m_init  = 0;
    bit              m_clean = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_fpc = '0;
            m_pcq.delete();
            m_opq.delete();
            m_init  = 1;
            m_clean = 1;
        end else if (m_init) begin
            if (redirect) begin
                m_pcq.delete();
                m_opq.delete();
                m_fpc = redirect_pc;
            end else begin
                bit p_pop, p_push;
                p_pop  = (m_pcq.size() != 0) && op_ready;
                p_push = (m_pcq.size() < DEPTH) || p_pop;
                if (p_pop) begin
                    void'(m_pcq.pop_front());
                    void'(m_opq.pop_front());
                end
                if (p_push) begin
                    m_pcq.push_back(m_fpc);
                    m_opq.push_back({{(OP_W-PC_W){1'b0}}, m_fpc} ^ key);
                    m_fpc   = m_fpc + 1'b1;
                    m_clean = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("model_addr", 32'(imem_addr), 32'(m_fpc));
            chk("model_count", 32'(count), 32'(m_pcq.size()));
            chk("model_valid", 32'(op_valid), 32'(m_pcq.size() != 0));
            if (m_pcq.size() != 0) begin
                chk("model_pc", 32'(op_pc), 32'(m_pcq[0]));
                chk("model_op", op_out, m_opq[0]);
            end else if (m_clean) begin
                chk("model_rst_pc", 32'(op_pc), 32'h0);
                chk("model_rst_op", op_out, 32'h0);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_addr"},  32'(imem_addr), 32'h0);
        chk({tag, "_valid"}, 32'(op_valid),  32'h0);
        chk({tag, "_count"}, 32'(count),     32'h0);
        chk({tag, "_pc"},    32'(op_pc),     32'h0);
        chk({tag, "_op"},    op_out,         32'h0);
    endtask

    initial begin
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; op_ready = 1'b1; key = '0;
        step(); step();
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Streaming with op_ready=1: one instruction per cycle, count stays 1.
        for (int i = 0; i < 6; i++) begin
            step();
            chk("stream_pc", 32'(op_pc), 32'(i));
            chk("stream_op", op_out, 32'(i));
            chk("stream_count", 32'(count), 32'd1);
        end

        // Decoder stalled: fill to DEPTH, then drain full with push+pop.
        rst_n = 1'b0; step(); rst_n = 1'b1; op_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("fill_count", 32'(count), 32'((i < 4) ? i : 4));
        end
        chk("fill_addr_hold", 32'(imem_addr), 32'd4);
        chk("fill_head", 32'(op_pc), 32'd0);
        op_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("full_pc", 32'(op_pc), 32'(k + 1));
            chk("full_count", 32'(count), 32'd4);
        end

        // Redirect with three buffered entries.
        rst_n = 1'b0; step(); rst_n = 1'b1; op_ready = 1'b0;
        step(); step(); step();
        chk("pre_redir_count", 32'(count), 32'd3);
        redirect = 1'b1; redirect_pc = 9'h1F0;
        step();
        redirect = 1'b0;
        chk("redir_valid", 32'(op_valid), 32'd0);
        chk("redir_count", 32'(count), 32'd0);
        chk("redir_addr", 32'(imem_addr), 32'h1F0);
        step();
        chk("redir_pc", 32'(op_pc), 32'h1F0);
        chk("redir_valid2", 32'(op_valid), 32'd1);

        // Address wrap from 0x1FE.
        op_ready = 1'b1; redirect = 1'b1; redirect_pc = 9'h1FE;
        step();
        redirect = 1'b0;
        chk("wrap_bubble", 32'(op_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("wrap_pc", 32'(op_pc), (k < 2) ? 32'h1FE + 32'(k) : 32'(k - 2));
        end

        // Reset and redirect on the same edge: reset wins.
        rst_n = 1'b0; redirect = 1'b1; redirect_pc = 9'h0AB;
        step();
        chk_reset_outputs("rst_vs_redir");
        rst_n = 1'b1; redirect = 1'b0;
        step();
        chk("rst_restart_pc", 32'(op_pc), 32'h0);
        chk("rst_restart_valid", 32'(op_valid), 32'd1);

        // Randomized traffic; the model compare covers these cycles.
        key = $urandom;
        for (int c = 0; c < 3000; c++) begin
            rst_n       = ($urandom_range(0, 99) != 0);
            redirect    = ($urandom_range(0, 9) == 0);
            redirect_pc = PC_W'($urandom);
            if ($urandom_range(0, 3) == 0) redirect_pc = 9'h1FC | PC_W'($urandom_range(0, 3));
            op_ready    = ($urandom_range(0, 9) < ((c / 500) % 2 == 0 ? 7 : 2));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
